// File: rtl/cdce_cfg_pkg.sv
// Shared definitions for the CDCE configuration sequencer: command fields, opcodes,
// error codes and the sequencer state encoding.
package cdce_cfg_pkg;

  localparam int unsigned CMD_W  = 24;
  localparam int unsigned ARG_W  = 16;
  localparam int unsigned WORD_W = 32;

  // Command field slices
  localparam int unsigned OP_MSB  = 23;
  localparam int unsigned OP_LSB  = 20;
  localparam int unsigned ARG_MSB = 15;

  localparam logic [3:0] OP_END       = 4'h0;
  localparam logic [3:0] OP_LOAD_HI   = 4'h1;
  localparam logic [3:0] OP_WRITE_LO  = 4'h2;
  localparam logic [3:0] OP_DELAY     = 4'h3;
  localparam logic [3:0] OP_WAIT_LOCK = 4'h4;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_OPCODE       = 2'd1;
  localparam logic [1:0] ERR_LOCK_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_PAST_END     = 2'd3;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StRomWait,
    StDecode,
    StSend,
    StDelay,
    StLock,
    StDone,
    StError
  } state_e;

endpackage

// File: rtl/cdce_delay_timer.sv
// Tick timer shared by DELAY and WAIT_LOCK: a DELAY_UNIT-cycle prescaler feeding a 16-bit
// down-counter. 'expired' is asserted during the last cycle of the programmed interval, or
// immediately when loaded with zero.
module cdce_delay_timer
  import cdce_cfg_pkg::*;
#(
  parameter int unsigned DELAY_UNIT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [ARG_W-1:0] arg,
  output logic             expired
);

  localparam int unsigned PRESC_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DELAY_UNIT - 1);

  logic [PRESC_W-1:0] presc_q;
  logic [ARG_W-1:0]   ticks_q;
  logic               tick_end;

  assign tick_end = (presc_q == PRESC_LAST);

  // Prescaler and tick counter; both freeze once the tick count reaches zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      ticks_q <= '0;
    end else if (load) begin
      presc_q <= '0;
      ticks_q <= arg;
    end else if (ticks_q != '0) begin
      if (tick_end) begin
        presc_q <= '0;
        ticks_q <= ticks_q - ARG_W'(1);
      end else begin
        presc_q <= presc_q + PRESC_W'(1);
      end
    end
  end

  // Flag the final cycle so the caller leaves exactly arg*DELAY_UNIT cycles after loading.
  always_comb begin
    expired = (ticks_q == '0) || ((ticks_q == ARG_W'(1)) && tick_end);
  end

endmodule

// File: rtl/cdce_config_sequencer.sv
// Walks the CDCE command ROM from address 0 after a start pulse, turning LOAD_HI/WRITE_LO
// pairs into 32-bit SPI words and handling timed delays and PLL-lock waits.
module cdce_config_sequencer
  import cdce_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned LAST_ADDR  = 255,
  parameter int unsigned DELAY_UNIT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [CMD_W-1:0]  rom_command,
  output logic [WORD_W-1:0] spi_word,
  output logic              spi_valid,
  input  logic              spi_ready,
  input  logic              pll_lock,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] rom_address_q;
  logic [ARG_W-1:0]  hold_q;
  logic [WORD_W-1:0] spi_word_q;
  logic [1:0]        err_code_q;

  logic [3:0]       op;
  logic [ARG_W-1:0] arg;
  logic             unused_cmd_bits;

  logic       run_clear;
  logic       addr_inc;
  logic       hold_load;
  logic       word_load;
  logic       err_set;
  logic [1:0] err_val;
  logic       timer_load;
  logic       timer_expired;
  logic       at_last;

  assign op              = rom_command[OP_MSB:OP_LSB];
  assign arg             = rom_command[ARG_MSB:0];
  assign unused_cmd_bits = ^rom_command[OP_LSB-1:ARG_MSB+1];
  assign at_last         = (rom_address_q == ADDR_W'(LAST_ADDR));

  cdce_delay_timer #(
    .DELAY_UNIT(DELAY_UNIT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .arg    (arg),
    .expired(timer_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus datapath strobes; "next" either advances the address or aborts at the top.
  always_comb begin
    state_d    = state_q;
    run_clear  = 1'b0;
    addr_inc   = 1'b0;
    hold_load  = 1'b0;
    word_load  = 1'b0;
    err_set    = 1'b0;
    err_val    = ERR_NONE;
    timer_load = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          run_clear = 1'b1;
          state_d   = StFetch;
        end
      end
      StFetch:   state_d = StRomWait;
      StRomWait: state_d = StDecode;
      StDecode: begin
        unique case (op)
          OP_END: state_d = StDone;
          OP_LOAD_HI: begin
            hold_load = 1'b1;
            state_d   = StFetch;
          end
          OP_WRITE_LO: begin
            word_load = 1'b1;
            state_d   = StSend;
          end
          OP_DELAY: begin
            if (arg == '0) begin
              state_d = StFetch;
            end else begin
              timer_load = 1'b1;
              state_d    = StDelay;
            end
          end
          OP_WAIT_LOCK: begin
            timer_load = 1'b1;
            state_d    = StLock;
          end
          default: begin
            err_set = 1'b1;
            err_val = ERR_OPCODE;
            state_d = StError;
          end
        endcase
      end
      StSend: begin
        if (spi_ready) state_d = StFetch;
      end
      StDelay: begin
        if (timer_expired) state_d = StFetch;
      end
      StLock: begin
        // Lock wins over a coinciding timeout.
        if (pll_lock) begin
          state_d = StFetch;
        end else if (timer_expired) begin
          err_set = 1'b1;
          err_val = ERR_LOCK_TIMEOUT;
          state_d = StError;
        end
      end
      default: state_d = StIdle;
    endcase

    // Common "next" handling for every path that advanced back to FETCH from inside the run.
    if ((state_d == StFetch) && (state_q != StFetch) && !run_clear) begin
      if (at_last) begin
        err_set = 1'b1;
        err_val = ERR_PAST_END;
        state_d = StError;
      end else begin
        addr_inc = 1'b1;
      end
    end
  end

  // Datapath registers: ROM address, high-half hold, SPI word and error code.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_address_q <= '0;
      hold_q        <= '0;
      spi_word_q    <= '0;
      err_code_q    <= ERR_NONE;
    end else begin
      if (run_clear) begin
        rom_address_q <= '0;
        hold_q        <= '0;
        err_code_q    <= ERR_NONE;
      end
      if (addr_inc)  rom_address_q <= rom_address_q + ADDR_W'(1);
      if (hold_load) hold_q <= arg;
      if (word_load) spi_word_q <= {hold_q, arg};
      if (err_set)   err_code_q <= err_val;
    end
  end

  // Moore outputs decoded from the state.
  always_comb begin
    busy      = 1'b0;
    spi_valid = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    unique case (state_q)
      StFetch, StRomWait, StDecode, StDelay, StLock: busy = 1'b1;
      StSend: begin
        busy      = 1'b1;
        spi_valid = 1'b1;
      end
      StDone:  done  = 1'b1;
      StError: error = 1'b1;
      default: ;
    endcase
  end

  assign rom_address = rom_address_q;
  assign spi_word    = spi_word_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_cdce_config_sequencer.sv
// Directed bench for cdce_config_sequencer with a registered-read ROM model (DELAY_UNIT=4).
module tb_cdce_config_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rom_address;
  logic [23:0] rom_command;
  logic [31:0] spi_word;
  logic        spi_valid;
  logic        spi_ready;
  logic        pll_lock;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  logic [23:0] rom [0:255];
  int checks   = 0;
  int failures = 0;
  int accepts  = 0;

  cdce_config_sequencer #(
    .ADDR_W    (8),
    .LAST_ADDR (255),
    .DELAY_UNIT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rom_address(rom_address),
    .rom_command(rom_command),
    .spi_word   (spi_word),
    .spi_valid  (spi_valid),
    .spi_ready  (spi_ready),
    .pll_lock   (pll_lock),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  // ROM with one cycle of read latency
  always @(posedge clk) rom_command <= rom[rom_address];

  always @(posedge clk) if (!reset && spi_valid && spi_ready) accepts <= accepts + 1;

  typedef struct {
    logic [23:0] c0, c1, c2, c3;
    logic        exp_done;
    logic        exp_error;
    logic [1:0]  exp_code;
    logic [31:0] exp_word;
    logic [7:0]  exp_addr;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic rom_fill(input logic [23:0] val);
    for (int i = 0; i < 256; i++) rom[i] = val;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for the run to end; an expired bound is reported as a failure.
  task automatic wait_end(input string name, input int max);
    int n;
    n = 0;
    while (!(done || error) && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (!(done || error)) begin
      failures++;
      $display("FAIL %s: no done/error within %0d cycles", name, max);
    end
  endtask

  // Counts edges after the start edge until the sequencer leaves address 0 or errors.
  task automatic delay_case(input logic [15:0] arg, input int exp_n);
    int n;
    rom_fill(24'h000000);
    rom[0] = {8'h30, arg};
    do_reset();
    pulse_start();
    n = 0;
    while (rom_address != 8'd1 && n < 60) begin
      tick();
      n++;
    end
    check($sformatf("delay_arg%0d_cycles", arg), n, exp_n);
  endtask

  task automatic lock_case(input logic [15:0] arg, input int raise_at, input int exp_n,
                           input logic exp_err);
    int n;
    rom_fill(24'h000000);
    rom[0] = {8'h40, arg};
    pll_lock = 1'b0;
    do_reset();
    pulse_start();
    n = 0;
    while (rom_address != 8'd1 && !error && n < 60) begin
      if (n == raise_at) pll_lock = 1'b1;
      tick();
      n++;
    end
    check($sformatf("lock_a%0d_r%0d_cycles", arg, raise_at), n, exp_n);
    check($sformatf("lock_a%0d_r%0d_error", arg, raise_at), error, exp_err);
    check($sformatf("lock_a%0d_r%0d_code", arg, raise_at), err_code, exp_err ? 2 : 0);
    pll_lock = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    spi_ready = 1'b1;
    pll_lock  = 1'b1;

    //            c0          c1          c2          c3          done  err   code  word          addr
    vecs[0] = '{24'h100ABC, 24'h20DEF0, 24'h000000, 24'h000000, 1'b1, 1'b0, 2'd0, 32'h0ABCDEF0, 8'd2};
    vecs[1] = '{24'h000000, 24'h000000, 24'h000000, 24'h000000, 1'b1, 1'b0, 2'd0, 32'h00000000, 8'd0};
    vecs[2] = '{24'h112345, 24'h2F6789, 24'h300000, 24'h700000, 1'b0, 1'b1, 2'd1, 32'h23456789, 8'd3};
    vecs[3] = '{24'h2F0001, 24'h400001, 24'h300002, 24'h000000, 1'b1, 1'b0, 2'd0, 32'h00000001, 8'd3};
    vecs[4] = '{24'hF00000, 24'h000000, 24'h000000, 24'h000000, 1'b0, 1'b1, 2'd1, 32'h00000000, 8'd0};
    vecs[5] = '{24'h1FFFFF, 24'h2FFFFF, 24'h500000, 24'h000000, 1'b0, 1'b1, 2'd1, 32'hFFFFFFFF, 8'd2};
    vecs[6] = '{24'h10BEEF, 24'h101234, 24'h2F0000, 24'h000000, 1'b1, 1'b0, 2'd0, 32'h12340000, 8'd3};

    rom_fill(24'h000000);
    do_reset();
    check("rst_rom_address", rom_address, 0);
    check("rst_spi_word", spi_word, 0);
    check("rst_spi_valid", spi_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);

    foreach (vecs[v]) begin
      rom_fill(24'h000000);
      rom[0] = vecs[v].c0;
      rom[1] = vecs[v].c1;
      rom[2] = vecs[v].c2;
      rom[3] = vecs[v].c3;
      do_reset();
      pulse_start();
      check($sformatf("v%0d_busy_after_start", v), busy, 1);
      wait_end($sformatf("v%0d_end", v), 200);
      check($sformatf("v%0d_done", v), done, vecs[v].exp_done);
      check($sformatf("v%0d_error", v), error, vecs[v].exp_error);
      check($sformatf("v%0d_err_code", v), err_code, vecs[v].exp_code);
      check($sformatf("v%0d_spi_word", v), spi_word, vecs[v].exp_word);
      check($sformatf("v%0d_rom_address", v), rom_address, vecs[v].exp_addr);
      check($sformatf("v%0d_busy_end", v), busy, 0);
    end

    // SPI backpressure: word held stable, exactly one accept.
    begin
      int n;
      int acc0;
      rom_fill(24'h000000);
      rom[0] = 24'h100ABC;
      rom[1] = 24'h20DEF0;
      spi_ready = 1'b0;
      do_reset();
      pulse_start();
      n = 0;
      while (!spi_valid && n < 20) begin
        tick();
        n++;
      end
      acc0 = accepts;
      for (int i = 0; i < 20; i++) begin
        check($sformatf("stall_valid_%0d", i), spi_valid, 1);
        check($sformatf("stall_word_%0d", i), spi_word, 32'h0ABCDEF0);
        tick();
      end
      spi_ready = 1'b1;
      tick();
      check("stall_valid_dropped", spi_valid, 0);
      wait_end("stall_end", 50);
      check("stall_accepts", accepts - acc0, 1);
      check("stall_done", done, 1);
    end

    // DELAY: arg ticks of 4 cycles after DECODE (DECODE sits 3 edges after start).
    delay_case(16'd3, 15);
    delay_case(16'd1, 7);
    delay_case(16'd0, 3);

    // WAIT_LOCK arg=2: 8 LOCK cycles, LOCK entered on the 3rd edge.
    lock_case(16'd2, -1, 11, 1'b1);
    lock_case(16'd2, 7, 8, 1'b0);
    lock_case(16'd2, 10, 11, 1'b0);
    lock_case(16'd0, -1, 4, 1'b1);

    // No END anywhere: abort at the last address.
    rom_fill(24'h100000);
    do_reset();
    pulse_start();
    wait_end("past_end", 2000);
    check("past_end_error", error, 1);
    check("past_end_code", err_code, 3);
    check("past_end_addr", rom_address, 255);
    check("past_end_done", done, 0);

    // start while busy is ignored.
    begin
      int n;
      rom_fill(24'h000000);
      rom[0] = 24'h100001;
      rom[1] = 24'h300005;
      do_reset();
      pulse_start();
      n = 0;
      while (rom_address != 8'd1 && n < 20) begin
        tick();
        n++;
      end
      for (int i = 0; i < 4; i++) tick();
      pulse_start();
      check("busy_start_addr", rom_address, 1);
      check("busy_start_busy", busy, 1);
      wait_end("busy_start_end", 100);
      check("busy_start_done", done, 1);
      check("busy_start_final_addr", rom_address, 2);
    end

    // Reset while a word is offered.
    begin
      int n;
      rom_fill(24'h000000);
      rom[0] = 24'h20DEF0;
      spi_ready = 1'b0;
      do_reset();
      pulse_start();
      n = 0;
      while (!spi_valid && n < 20) begin
        tick();
        n++;
      end
      check("midrst_valid_before", spi_valid, 1);
      reset = 1'b1;
      tick();
      check("midrst_spi_valid", spi_valid, 0);
      check("midrst_spi_word", spi_word, 0);
      check("midrst_busy", busy, 0);
      check("midrst_addr", rom_address, 0);
      check("midrst_done_error", {done, error, err_code}, 0);
      reset = 1'b0;
      spi_ready = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
